// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined chunked adder with valid/ready handshake
//
// Splits a WIDTH-bit a + b + cin into STAGES chunks of CHUNK = WIDTH/STAGES
// bits. Each stage adds one chunk and registers its carry for the next stage.
// Operand bits still to be added and finished sum chunks travel alongside.
//
// Optional feature macro: PIPE_ADDER_OVF_EN
//   defined   : ovf reports signed overflow, registered with the last stage
//   undefined : ovf is tied to 0
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   in_valid  operands a, b, cin are valid
//   in_ready  pipe can accept operands (combinational)
//   a, b      WIDTH-bit addends
//   cin       carry into bit 0
//   out_valid sum, cout, ovf are valid
//   out_ready downstream accepts the result
//   sum       (a + b + cin) mod 2^WIDTH
//   cout      carry out of bit WIDTH-1
//   ovf       signed overflow
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // Stage registers: entry k holds the state after chunk k has been added.
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];

  logic             valid_d [STAGES];
  logic             carry_d [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];

  logic             src_valid;
  logic             src_carry;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_sum;
  logic [CHUNK:0]   part;
  logic             adv;

  // The whole pipe moves together; only a stalled valid result freezes it,
  // so empty stages (bubbles) never block anything behind them.
  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    src_valid = 1'b0;
    src_carry = 1'b0;
    src_a     = '0;
    src_b     = '0;
    src_sum   = '0;
    part      = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        src_valid = in_valid;
        src_carry = cin;
        src_a     = a;
        src_b     = b;
        src_sum   = '0;
      end else begin
        src_valid = valid_q[k-1];
        src_carry = carry_q[k-1];
        src_a     = a_q[k-1];
        src_b     = b_q[k-1];
        src_sum   = sum_q[k-1];
      end
      // One chunk of ripple addition; the extra top bit is the chunk carry.
      part = {1'b0, src_a[k*CHUNK +: CHUNK]}
           + {1'b0, src_b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src_carry};
      valid_d[k]                    = src_valid;
      carry_d[k]                    = part[CHUNK];
      a_d[k]                        = src_a;
      b_d[k]                        = src_b;
      sum_d[k]                      = src_sum;
      sum_d[k][k*CHUNK +: CHUNK]    = part[CHUNK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
  // Sign bits entering the last stage are the original operand MSBs; the
  // result MSB is produced in that same stage, so the flag lines up with sum.
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1])
             && (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined N-bit adder built from registered full-adder chunks: a WIDTH-bit addition with carry-in is split into STAGES equal chunks, each stage adding one chunk and registering the carry forward. It replaces single-cycle ripple addition in wide datapaths where the carry chain would limit clock rate. It accepts one operation per cycle through a valid/ready handshake and propagates downstream backpressure.

## Interface
- WIDTH, 8, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages; CHUNK = WIDTH/STAGES bits are added per stage; STAGES >= 1.

- clk  input  1  rising-edge clock; the block's single clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  addend A, unsigned or two's complement.
- b  input  WIDTH  addend B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum, cout, ovf are valid.
- out_ready  input  1  downstream accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow (see Configuration).

## Operation
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of a and b plus the carry from stage k-1 (stage 0 uses cin); per-bit function is y = A^B^C, cout = AB|AC|BC.
- Operand bits not yet consumed are carried forward in stage registers; finished sum chunks are carried forward unchanged. Each stage holds a valid bit.
- Global advance: adv = !out_valid | out_ready. When adv = 1 every stage register loads from its predecessor; stage 0 loads from inputs, with valid = in_valid. When adv = 0 all stage registers hold.
- in_ready = adv (combinational from out_valid and out_ready). Transfer in when in_valid & in_ready; out when out_valid & out_ready.
- Bubbles propagate: a stage whose valid is 0 still advances, so a bubble never blocks a later valid.
- Results leave in input order; no reordering, dropping or duplication.
- in_valid with in_ready = 0: operands are not captured; the producer must hold them.

## Timing
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready stays 1.
- Throughput: one result per cycle with out_ready held high.
- Stall: out_valid = 1 and out_ready = 0 freezes the whole pipe; sum, cout and ovf are held stable until accepted.
- Simultaneous output accept and input transfer in one cycle is permitted and loses nothing.
- Reset: on a clk edge with reset = 1, all valid bits and data registers clear. After reset out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1. Reset mid-operation discards all in-flight results; the in_valid value sampled on the reset edge is ignored.
- Only registers feed sum, cout, ovf and out_valid; in_ready is the only combinational output.

## Configuration
- PIPE_ADDER_OVF_EN defined: ovf = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]), computed in the last stage from registered sign bits and timed with sum.
- Undefined: ovf is tied to 0 and no sign-bit registers are built.

## Test plan
- WIDTH=8, STAGES=2: a=8'hFF, b=8'h01, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=8'h00, cout=1.
- WIDTH=4, STAGES=1: all 512 combinations of a, b, cin -> sum and cout match a+b+cin, latency 1, zero failures reported.
- WIDTH=8, STAGES=4: 10 back-to-back random vectors, out_ready=1 -> 10 consecutive out_valid cycles after a 4-cycle latency, in order, all correct.
- Backpressure: stream of 6 vectors with out_ready=0 for cycles 3-7 -> in_ready=0 whenever out_valid=1, outputs held stable, all 6 results delivered in order.
- Reset mid-stream: assert reset for 1 cycle with 2 results in flight -> out_valid=0 and sum=0 on the next cycle; no stale result appears afterwards.
- PIPE_ADDER_OVF_EN defined: 8'h7F+8'h01 -> sum=8'h80, ovf=1; 8'hFF+8'h01 -> ovf=0. Undefined: ovf=0 for both.
